// File: rtl/gshare_spec_predictor.sv
// Gshare direction predictor with speculative global history, checkpoint repair
// on mispredict, and a sequential counter-table init sweep after reset.
module gshare_spec_predictor #(
    parameter int IDX_BITS  = 6,
    parameter int HIST_BITS = 6,
    parameter int CTR_BITS  = 2,
    parameter int PC_WIDTH  = 10,
    parameter int PC_SHIFT  = 0,
    parameter logic [CTR_BITS-1:0] INIT_CTR = {CTR_BITS{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 init_done,
    input  logic                 f_valid,
    input  logic [PC_WIDTH-1:0]  f_pc,
    output logic                 f_pred,
    output logic [IDX_BITS-1:0]  f_idx,
    output logic [HIST_BITS-1:0] f_hist,
    input  logic                 ex_valid,
    input  logic                 ex_taken,
    input  logic                 ex_mispredict,
    input  logic [IDX_BITS-1:0]  ex_idx,
    input  logic [HIST_BITS-1:0] ex_hist
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [IDX_BITS-1:0] LAST_IDX = {IDX_BITS{1'b1}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state;
    state_t               state_next;
    logic [IDX_BITS-1:0]  init_ptr;
    logic [HIST_BITS-1:0] ghr;
    logic [HIST_BITS-1:0] ghr_next;
    logic [CTR_BITS-1:0]  ctr [ENTRIES];
    logic [CTR_BITS-1:0]  ex_ctr;
    logic [CTR_BITS-1:0]  ex_ctr_trained;
    logic                 unused_bits;

    assign unused_bits = ^{f_pc, ex_hist};

    assign init_done = (state == ST_RUN);
    assign f_idx     = f_pc[PC_SHIFT +: IDX_BITS] ^ IDX_BITS'(ghr);
    assign f_hist    = ghr;
    assign f_pred    = ctr[f_idx][CTR_BITS-1] & f_valid & init_done;

    assign ex_ctr = ctr[ex_idx];

    always_comb begin
        ex_ctr_trained = ex_ctr;
        if (ex_taken && ex_ctr != CTR_MAX) begin
            ex_ctr_trained = ex_ctr + 1'b1;
        end else if (!ex_taken && ex_ctr != '0) begin
            ex_ctr_trained = ex_ctr - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Mispredict repair outranks the speculative fetch shift; shifting via a
    // truncating cast keeps HIST_BITS = 1 legal.
    always_comb begin
        state_next = state;
        ghr_next   = ghr;
        case (state)
            ST_INIT: begin
                if (init_ptr == LAST_IDX) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ex_valid && ex_mispredict) begin
                    ghr_next = HIST_BITS'({ex_hist, ex_taken});
                end else if (f_valid) begin
                    ghr_next = HIST_BITS'({ghr, f_pred});
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ghr      <= '0;
            init_ptr <= '0;
        end else begin
            ghr <= ghr_next;
            if (state == ST_INIT) begin
                init_ptr <= init_ptr + 1'b1;
            end
        end
    end

    // Table has no reset; the sweep defines it, and reset cycles drop training.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_INIT) begin
                ctr[init_ptr] <= INIT_CTR;
            end else if (ex_valid) begin
                ctr[ex_idx] <= ex_ctr_trained;
            end
        end
    end

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Scoreboard bench for gshare_spec_predictor (3-bit index/history, 2-bit counters).
module tb_gshare_spec_predictor;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done;
    logic       f_valid;
    logic [9:0] f_pc;
    logic       f_pred;
    logic [2:0] f_idx;
    logic [2:0] f_hist;
    logic       ex_valid;
    logic       ex_taken;
    logic       ex_mispredict;
    logic [2:0] ex_idx;
    logic [2:0] ex_hist;

    typedef struct {
        logic       done;
        logic       pred;
        logic [2:0] idx;
        logic [2:0] hist;
        string      tag;
    } exp_t;

    exp_t sb[$];

    int         checks   = 0;
    int         failures = 0;
    int         m_ctr[8];
    logic [2:0] m_ghr;
    bit         m_done;
    int         m_ptr;

    gshare_spec_predictor #(
        .IDX_BITS(3), .HIST_BITS(3), .CTR_BITS(2), .PC_WIDTH(10), .PC_SHIFT(0)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .f_valid(f_valid), .f_pc(f_pc), .f_pred(f_pred), .f_idx(f_idx), .f_hist(f_hist),
        .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_mispredict(ex_mispredict),
        .ex_idx(ex_idx), .ex_hist(ex_hist)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle: predicts outputs from the model, compares at negedge, then advances the model at posedge.
    task automatic applyStimulus(input logic r, input logic fv, input logic [9:0] pc,
                                 input logic exv, input logic ext, input logic exm,
                                 input logic [2:0] exi, input logic [2:0] exh, input string tag);
        exp_t e;
        exp_t got;
        logic pred_now;
        rst = r; f_valid = fv; f_pc = pc;
        ex_valid = exv; ex_taken = ext; ex_mispredict = exm; ex_idx = exi; ex_hist = exh;
        e.idx  = pc[2:0] ^ m_ghr;
        e.hist = m_ghr;
        e.done = m_done;
        e.pred = m_done && fv && (m_ctr[e.idx] >= 2);
        e.tag  = tag;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        checkOutput({got.tag, ".init_done"}, 32'(init_done), 32'(got.done));
        checkOutput({got.tag, ".f_pred"},    32'(f_pred),    32'(got.pred));
        checkOutput({got.tag, ".f_idx"},     32'(f_idx),     32'(got.idx));
        checkOutput({got.tag, ".f_hist"},    32'(f_hist),    32'(got.hist));
        pred_now = e.pred;
        @(posedge clk);
        if (!r) begin
            m_ghr = 3'b000; m_ptr = 0; m_done = 0;
        end else if (!m_done) begin
            m_ctr[m_ptr] = 3;
            if (m_ptr == 7) m_done = 1;
            m_ptr = (m_ptr + 1) % 8;
        end else begin
            if (exv && exm) m_ghr = {exh[1:0], ext};
            else if (fv)    m_ghr = {m_ghr[1:0], pred_now};
            if (exv) begin
                if (ext && m_ctr[exi] < 3)       m_ctr[exi] = m_ctr[exi] + 1;
                else if (!ext && m_ctr[exi] > 0) m_ctr[exi] = m_ctr[exi] - 1;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b0; f_valid = 0; f_pc = '0;
        ex_valid = 0; ex_taken = 0; ex_mispredict = 0; ex_idx = '0; ex_hist = '0;
        repeat (2) @(posedge clk);
        #1;
        m_ghr = 3'b000; m_done = 0; m_ptr = 0;
        for (int i = 0; i < 8; i++) m_ctr[i] = 0;

        applyStimulus(0, 1, 10'd6, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 8; i++)
            applyStimulus(1, (i == 2), 10'd5, (i == 4), 0, 1, 3'd1, 3'd7, "sweep");
        applyStimulus(1, 1, 10'd0, 0, 0, 0, 0, 0, "live");

        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1, 10'(3'd5 ^ m_ghr), 1, 0, 0, 3'd5, 0, "sat_dn");
        applyStimulus(1, 1, 10'(3'd5 ^ m_ghr), 0, 0, 0, 0, 0, "sat_low");
        for (int i = 0; i < 2; i++)
            applyStimulus(1, 1, 10'(3'd5 ^ m_ghr), 1, 1, 0, 3'd5, 0, "sat_up");
        applyStimulus(1, 1, 10'(3'd5 ^ m_ghr), 0, 0, 0, 0, 0, "sat_back");

        applyStimulus(1, 0, 10'd0, 1, 0, 1, 3'd7, 3'b000, "hist_clr");
        applyStimulus(1, 1, 10'd0, 0, 0, 0, 0, 0, "spec1");
        applyStimulus(1, 1, 10'd0, 0, 0, 0, 0, 0, "spec2");
        applyStimulus(1, 0, 10'd0, 0, 0, 0, 0, 0, "spec_chk");

        applyStimulus(1, 1, 10'd4, 1, 0, 1, 3'd2, 3'b101, "recover");
        applyStimulus(1, 0, 10'd0, 0, 0, 0, 0, 0, "recover_chk");

        applyStimulus(0, 1, 10'd3, 1, 0, 1, 3'd0, 3'b111, "midreset");
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 0, 10'd0, 1, 0, 1, 3'(i), 3'b010, "resweep");
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 1, 10'(i), 0, 0, 0, 0, 0, "readback");

        for (int i = 0; i < 40; i++)
            applyStimulus(1, 1'($urandom_range(0, 1)), 10'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), "random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
